board_row_reader: RTL and testbench

Display-side reader for the game-board memory. On each `frame_start` it walks board rows 0..NUM_ROWS-1 through the memory's row read port (`row_index` out, `row_data`/`line_status` in). It unpacks each 32-bit row word into per-cell codes and streams them to the graphics path over a valid/ready interface, one cell per accepted beat. It is the consumer of the row data that the CPU memory-access stage exposes, and sits between the board memory and the pixel/tile renderer.

---
 rtl/board_pkg.sv | 15 +
 rtl/board_row_reader.sv | 94 +++++++++
 tb/tb_board_row_reader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, cell codes and reader FSM states
// for the board display path.
package board_pkg;
    localparam int NUM_ROWS = 20;
    localparam int NUM_COLS = 10;
    localparam int CELL_W   = 3;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY  = 3'd0,
        CELL_LINE   = 3'd1,
        CELL_SQUARE = 3'd2
    } cell_code_e;

    typedef enum logic [1:0] {IDLE, REQ, EMIT, DONE} state_e;
endpackage

// File: rtl/board_row_reader.sv
// board_row_reader: scans every board row once per frame and streams the
// unpacked cell codes to the renderer over a valid/ready interface.
module board_row_reader #(
    parameter int NUM_ROWS = board_pkg::NUM_ROWS,
    parameter int NUM_COLS = board_pkg::NUM_COLS,
    parameter int CELL_W   = board_pkg::CELL_W,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic [4:0]        row_index,
    input  logic [31:0]       row_data,
    input  logic [31:0]       line_status,
    output logic              cell_valid,
    input  logic              cell_ready,
    output logic [3:0]        cell_x,
    output logic [4:0]        cell_y,
    output logic [CELL_W-1:0] cell_code,
    output logic              row_full,
    output logic              busy,
    output logic              frame_done
);
    import board_pkg::*;

    localparam logic [7:0] LAT      = 8'(RD_LAT);
    localparam logic [3:0] LAST_COL = 4'(NUM_COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(NUM_ROWS - 1);

    state_e      r_state;
    logic [4:0]  r_row;
    logic [7:0]  r_cnt;
    logic [31:0] r_word;
    logic [3:0]  w_next_x;

    assign w_next_x  = cell_x + 4'd1;
    assign row_index = r_row;
    assign cell_y    = r_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            cell_valid <= 1'b0;
            cell_x     <= '0;
            cell_code  <= '0;
            row_full   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                IDLE: if (frame_start) begin
                    r_state <= REQ;
                    r_row   <= '0;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                end
                REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    // row_index has been stable RD_LAT cycles: the memory word is now valid
                    if (r_cnt == LAT) begin
                        r_word     <= row_data;
                        row_full   <= line_status[r_row];
                        cell_x     <= '0;
                        cell_code  <= row_data[CELL_W-1:0];
                        cell_valid <= 1'b1;
                        r_state    <= EMIT;
                    end
                end
                EMIT: if (cell_ready) begin
                    if (cell_x != LAST_COL) begin
                        cell_x    <= w_next_x;
                        cell_code <= r_word[w_next_x*CELL_W +: CELL_W];
                    end else if (r_row != LAST_ROW) begin
                        cell_valid <= 1'b0;
                        r_row      <= r_row + 5'd1;
                        r_cnt      <= '0;
                        r_state    <= REQ;
                    end else begin
                        cell_valid <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_row_reader.sv
// tb_board_row_reader: directed frames against three read-latency builds
// with a latency-aware board memory model.
module tb_board_row_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  fs, rdy, vld, fdone, busy_o, rfull;
    logic [4:0]  ridx[3], cy[3];
    logic [3:0]  cx[3];
    logic [2:0]  code[3];
    logic [31:0] rdata[3];
    logic [31:0] ls;
    bit          pat;
    int          n_checks = 0, n_pass = 0;
    int          ex[3], ey[3], beats[3], dones[3];

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 0 : 3;
    endfunction

    function automatic logic [2:0] exp_code(input int r, input int c, input bit p);
        return p ? 3'((r * 3 + c * 5 + 1) % 8) : 3'(r % 3);
    endfunction

    function automatic logic [31:0] row_word(input logic [4:0] r, input bit p);
        logic [31:0] w = p ? 32'hC000_0000 : 32'h0;
        for (int c = 0; c < 10; c++) w[c*3 +: 3] = exp_code(int'(r), c, p);
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        logic [4:0] prev = '0;
        int         age  = 99;
        board_row_reader #(.RD_LAT(L)) u_dut (
            .clk(clk), .rst(rst), .frame_start(fs[g]), .row_index(ridx[g]),
            .row_data(rdata[g]), .line_status(ls), .cell_valid(vld[g]),
            .cell_ready(rdy[g]), .cell_x(cx[g]), .cell_y(cy[g]),
            .cell_code(code[g]), .row_full(rfull[g]), .busy(busy_o[g]),
            .frame_done(fdone[g])
        );
        // age = cycles since the last address change; all-ones poison until it reaches L
        always @(posedge clk) begin
            prev <= ridx[g];
            age  <= (ridx[g] != prev) ? 1 : (age < 99 ? age + 1 : age);
        end
        assign rdata[g] = (((ridx[g] != prev) ? 0 : age) >= L) ? row_word(ridx[g], pat) : '1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input int g);
        if (vld[g] && rdy[g]) begin
            check($sformatf("d%0d_y", g), cy[g], ey[g]);
            check($sformatf("d%0d_x", g), cx[g], ex[g]);
            check($sformatf("d%0d_code", g), code[g], exp_code(ey[g], ex[g], pat));
            check($sformatf("d%0d_row_full", g), rfull[g], ls[ey[g]]);
            beats[g]++;
            ex[g]++;
            if (ex[g] == 10) begin ex[g] = 0; ey[g]++; end
        end
        if (fdone[g]) dones[g]++;
    endtask

    task automatic check_reset_outputs(input string pre);
        check({pre, "_row_index"}, ridx[0], 0);
        check({pre, "_cell_valid"}, vld[0], 0);
        check({pre, "_cell_x"}, cx[0], 0);
        check({pre, "_cell_y"}, cy[0], 0);
        check({pre, "_cell_code"}, code[0], 0);
        check({pre, "_row_full"}, rfull[0], 0);
        check({pre, "_busy"}, busy_o[0], 0);
        check({pre, "_frame_done"}, fdone[0], 0);
    endtask

    task automatic run_frame(input logic [2:0] mask, input int bp_y, input int bp_x,
                             input int rst_y, input int rst_x, input bit stray);
        int cyc = 0, held = 0;
        int dcyc[3];
        bit hit7 = 0;
        for (int g = 0; g < 3; g++) begin
            ex[g] = 0; ey[g] = 0; beats[g] = 0; dones[g] = 0; dcyc[g] = 0;
        end
        fs = mask;
        @(negedge clk);
        while (cyc < 1000 && ((dones[0] > 0 || !mask[0]) && (dones[1] > 0 || !mask[1])
               && (dones[2] > 0 || !mask[2])) == 0) begin
            cyc++;
            fs  = '0;
            rdy = 3'b111;
            if (vld[0] && int'(cy[0]) == bp_y && int'(cx[0]) == bp_x && held < 5) begin
                rdy[0] = 1'b0;
                held++;
                check("bp_hold_x", cx[0], bp_x);
                check("bp_hold_y", cy[0], bp_y);
                check("bp_hold_code", code[0], exp_code(bp_y, bp_x, pat));
            end
            if (stray && vld[0] && cy[0] == 5'd7 && cx[0] == 4'd5 && !hit7) begin
                fs[0] = 1'b1;
                hit7  = 1;
            end
            if (stray && fdone[0]) fs[0] = 1'b1;
            if (mask[0] && dones[0] == 0) check(fdone[0] ? "busy_in_done" : "busy_in_frame", busy_o[0], !fdone[0]);
            if (rst_y >= 0 && vld[0] && int'(cy[0]) == rst_y && int'(cx[0]) == rst_x) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    check("abort_no_done", fdone[0], 0);
                    check("abort_idle_busy", busy_o[0], 0);
                end
                return;
            end
            for (int g = 0; g < 3; g++) begin
                if (fdone[g] && dones[g] == 0) dcyc[g] = cyc;
                step(g);
            end
            @(negedge clk);
        end
        repeat (20) begin
            fs = '0;
            for (int g = 0; g < 3; g++) step(g);
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) if (mask[g]) begin
            check($sformatf("d%0d_beats", g), beats[g], 200);
            check($sformatf("d%0d_done_count", g), dones[g], 1);
            check($sformatf("d%0d_done_cycle", g), dcyc[g],
                  20 * (lat_of(g) + 11) + 1 + ((g == 0 && bp_y >= 0) ? 5 : 0));
            check($sformatf("d%0d_busy_after", g), busy_o[g], 0);
        end
    endtask

    initial begin
        rst = 1'b1; fs = '0; rdy = 3'b111; ls = 32'h0000_0021; pat = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        // all latencies together, stray frame_start mid row 7 and in DONE
        run_frame(3'b111, -1, -1, -1, -1, 1);
        // varied cell pattern with backpressure on beat (3,4)
        pat = 1; ls = 32'h8004_2410;
        run_frame(3'b001, 3, 4, -1, -1, 0);
        // abort mid-frame, then a clean restart from (0,0)
        pat = 0; ls = 32'h000F_0002;
        run_frame(3'b001, -1, -1, 12, 6, 0);
        run_frame(3'b001, -1, -1, -1, -1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
